pulse_evt_tx: RTL and testbench

- Source-domain transmitter that feeds the handshake pulse synchronizer.
- Accepts event pulses at any rate (up to one per cycle) and holds them in a pending counter.
- Issues one single-cycle valid per event, and only when the synchronizer reports ready.
- Watches each handshake for a stall and reports overflow and timeout errors.
- Sits entirely in the source clock domain, directly in front of the synchronizer's valid/ready pair.

---
 rtl/pulse_evt_tx_pkg.sv | 18 +
 rtl/pulse_evt_tx_timer.sv | 43 ++++
 rtl/pulse_evt_tx.sv | 143 ++++++++++++++
 tb/tb_pulse_evt_tx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_evt_tx_pkg.sv
`default_nettype none
// ============================================================================
// pulse_evt_tx_pkg : shared types and default constants for pulse_evt_tx
// Rev 1.0
// ============================================================================
package pulse_evt_tx_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DROP = 2'd1,
      WAIT_RISE = 2'd2
   } state_e;

   localparam int CNT_W_DEF   = 4;
   localparam int TIMEOUT_DEF = 256;

endpackage
`default_nettype wire

// File: rtl/pulse_evt_tx_timer.sv
`default_nettype none
// ============================================================================
// pulse_evt_tx_timer : clearable, enabled, saturating handshake stall timer
// Rev 1.0
// ============================================================================
module pulse_evt_tx_timer #(
   parameter int TIMEOUT = 256,
   parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [TO_W-1:0] c_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // Holds at the last value rather than wrapping; the owner leaves the wait on expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != c_LAST)) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && !clr_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pulse_evt_tx.sv
`default_nettype none
// ============================================================================
// pulse_evt_tx : source-domain event transmitter feeding a handshake pulse sync
// Optional macro PULSE_EVT_TX_STATS_EN adds issued_cnt_o.   Rev 1.0
// ============================================================================
module pulse_evt_tx
   import pulse_evt_tx_pkg::*;
#(
   parameter int  CNT_W   = CNT_W_DEF,
   parameter int  TIMEOUT = TIMEOUT_DEF,
   localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
`ifdef PULSE_EVT_TX_STATS_EN
   output logic [15:0]      issued_cnt_o,
`endif
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             event_i,
   input  logic             clr_i,
   input  logic             sync_ready_i,
   output logic             sync_valid_o,
   output logic [CNT_W-1:0] pending_o,
   output logic             busy_o,
   output logic             overflow_o,
   output logic             timeout_o
);

   localparam logic [CNT_W-1:0] c_PEND_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_PEND_ONE = CNT_W'(1);

   state_e           state_q;
   state_e           state_d;
   logic             valid_q;
   logic             valid_d;
   logic [CNT_W-1:0] pending_q;
   logic [CNT_W-1:0] pending_d;
   logic             overflow_q;
   logic             overflow_d;
   logic             timeout_q;
   logic             timeout_d;

   logic w_issue;
   logic w_drop;
   logic w_wait;
   logic w_expire;

   assign w_wait  = (state_q != IDLE);
   assign w_issue = (state_q == IDLE) && sync_ready_i && ((pending_q != '0) || event_i);
   // An event coinciding with an issue is passed straight through, so it is never dropped.
   assign w_drop  = event_i && !w_issue && (pending_q == c_PEND_MAX);

   pulse_evt_tx_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timer (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .clr_i    (w_issue),
      .en_i     (w_wait),
      .expire_o (w_expire)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (w_issue) state_d = WAIT_DROP;
         end
         WAIT_DROP: begin
            if (w_expire)          state_d = IDLE;
            else if (!sync_ready_i) state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (w_expire || sync_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_d   = w_issue;
      pending_d = pending_q;
      case ({event_i, w_issue})
         2'b10:   if (!w_drop) pending_d = pending_q + c_PEND_ONE;
         2'b01:   pending_d = pending_q - c_PEND_ONE;
         default: pending_d = pending_q;
      endcase

      // Sticky flags: a set condition on the same edge as clr_i wins.
      overflow_d = overflow_q;
      if (w_drop)     overflow_d = 1'b1;
      else if (clr_i) overflow_d = 1'b0;

      timeout_d = timeout_q;
      if (w_expire)   timeout_d = 1'b1;
      else if (clr_i) timeout_d = 1'b0;
   end

   assign sync_valid_o = valid_q;
   assign pending_o    = pending_q;
   assign busy_o       = w_wait;
   assign overflow_o   = overflow_q;
   assign timeout_o    = timeout_q;

`ifdef PULSE_EVT_TX_STATS_EN
   logic [15:0] issued_q;
   logic [15:0] issued_d;

   always_comb begin
      issued_d = issued_q;
      if (clr_i)        issued_d = w_issue ? 16'd1 : 16'd0;
      else if (w_issue) issued_d = issued_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         issued_q <= 16'd0;
      end else begin
         issued_q <= issued_d;
      end
   end

   assign issued_cnt_o = issued_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_evt_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pulse_evt_tx : table-driven and scoreboarded bench for pulse_evt_tx
// Rev 1.0
// ============================================================================
module tb_pulse_evt_tx;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic rstn_i = 1'b0;

   // Instance A: CNT_W=4, TIMEOUT=16.  Instance B: CNT_W=2, TIMEOUT=256.
   logic       ev_a = 1'b0, clr_a = 1'b0, rdy_a;
   logic       valid_a, busy_a, ovf_a, to_a;
   logic [3:0] pend_a;
   logic       ev_b = 1'b0, clr_b = 1'b0, rdy_b;
   logic       valid_b, busy_b, ovf_b, to_b;
   logic [1:0] pend_b;
`ifdef PULSE_EVT_TX_STATS_EN
   logic [15:0] issued_a, issued_b;
`endif

   pulse_evt_tx #(.CNT_W(4), .TIMEOUT(16)) u_dut_a (
`ifdef PULSE_EVT_TX_STATS_EN
      .issued_cnt_o (issued_a),
`endif
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .event_i      (ev_a),
      .clr_i        (clr_a),
      .sync_ready_i (rdy_a),
      .sync_valid_o (valid_a),
      .pending_o    (pend_a),
      .busy_o       (busy_a),
      .overflow_o   (ovf_a),
      .timeout_o    (to_a)
   );

   pulse_evt_tx #(.CNT_W(2), .TIMEOUT(256)) u_dut_b (
`ifdef PULSE_EVT_TX_STATS_EN
      .issued_cnt_o (issued_b),
`endif
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .event_i      (ev_b),
      .clr_i        (clr_b),
      .sync_ready_i (rdy_b),
      .sync_valid_o (valid_b),
      .pending_o    (pend_b),
      .busy_o       (busy_b),
      .overflow_o   (ovf_b),
      .timeout_o    (to_b)
   );

   // Synchronizer ready model: low from the cycle after valid is sampled, high 6 cycles later.
   int unsigned rcnt_a = 0, rcnt_b = 0;
   logic stuck_mode_a = 1'b0, stuck_q_a = 1'b0, force_low_b = 1'b0;

   always @(posedge clk_i) begin
      if (valid_a) rcnt_a <= 6;
      else if (rcnt_a != 0) rcnt_a <= rcnt_a - 1;
      if (!stuck_mode_a) stuck_q_a <= 1'b0;
      else if (valid_a) stuck_q_a <= 1'b1;
      if (valid_b) rcnt_b <= 6;
      else if (rcnt_b != 0) rcnt_b <= rcnt_b - 1;
   end

   assign rdy_a = (rcnt_a == 0) && !stuck_q_a;
   assign rdy_b = (rcnt_b == 0) && !force_low_b;

   int n_vec  = 0;
   int n_fail = 0;
   int q_a[$];
   int q_b[$];
   int pulses_a = 0, pulses_b = 0;
   int peak_a = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and run the scoreboard on both instances.
   task automatic step();
      @(negedge clk_i);
      if (valid_a) begin
         pulses_a++;
         chk("a_valid_not_back_to_back", int'(prev_a), 0);
         chk("a_pulse_expected", int'(q_a.size() != 0), 1);
         if (q_a.size() != 0) void'(q_a.pop_front());
      end
      if (valid_b) begin
         pulses_b++;
         chk("b_valid_not_back_to_back", int'(prev_b), 0);
         chk("b_pulse_expected", int'(q_b.size() != 0), 1);
         if (q_b.size() != 0) void'(q_b.pop_front());
      end
      prev_a = valid_a;
      prev_b = valid_b;
      if (int'(pend_a) > peak_a) peak_a = int'(pend_a);
   endtask

   task automatic drive_events_a(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         ev_a = 1'b1;
         q_a.push_back(i);
         step();
         ev_a = 1'b0;
         repeat (gap) step();
      end
   endtask

   task automatic wait_quiet(input bit sel, input string tag);
      int n;
      n = 0;
      while (n < 300 && (sel ? (busy_b || pend_b != 0 || q_b.size() != 0)
                             : (busy_a || pend_a != 0 || q_a.size() != 0))) begin
         step();
         n++;
      end
      chk({tag, "_drain_in_budget"}, int'(n < 300), 1);
      repeat (2) step();
      chk({tag, "_scoreboard_empty"}, sel ? q_b.size() : q_a.size(), 0);
   endtask

   typedef struct {
      int n;
      int gap;
      int exp_pulses;
      int exp_peak;
   } vec_t;

   vec_t vecs[6];
   int   p0;
   int   busy_n;
   int   extra;

   initial begin
      vecs[0] = '{1, 0, 1, 0};
      vecs[1] = '{5, 0, 5, 4};   // burst: first bypasses, rest queue up
      vecs[2] = '{4, 2, 4, 2};   // 4th event lands on an issue edge
      vecs[3] = '{2, 11, 2, 0};  // both events bypass
      vecs[4] = '{9, 0, 9, 8};
      vecs[5] = '{3, 7, 3, 1};

      // ---- reset state
      repeat (3) step();
      chk("rst_a_valid", int'(valid_a), 0);
      chk("rst_a_pending", int'(pend_a), 0);
      chk("rst_a_busy", int'(busy_a), 0);
      chk("rst_a_flags", int'({ovf_a, to_a}), 0);
      chk("rst_b_all", int'({valid_b, pend_b, busy_b, ovf_b, to_b}), 0);
      rstn_i = 1'b1;

      // ---- single event at cycle 10
      repeat (10) step();
      ev_a = 1'b1;
      q_a.push_back(0);
      step();
      ev_a = 1'b0;
      chk("single_valid_latency", int'(valid_a), 1);
      chk("single_pending_bypass", int'(pend_a), 0);
      chk("single_busy_first", int'(busy_a), 1);
      busy_n = 0;
      extra  = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy_a) busy_n++;
         if (i > 0 && valid_a) extra++;
         if (i == 1) chk("single_valid_one_cycle", int'(valid_a), 0);
         step();
      end
      chk("single_busy_cycles", busy_n, 8);
      chk("single_no_extra_pulse", extra, 0);
      chk("single_pending_end", int'(pend_a), 0);

      // ---- table-driven event patterns
      foreach (vecs[i]) begin
         p0     = pulses_a;
         peak_a = 0;
         drive_events_a(vecs[i].n, vecs[i].gap);
         wait_quiet(1'b0, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_pulses", i), pulses_a - p0, vecs[i].exp_pulses);
         chk($sformatf("vec%0d_peak_pending", i), peak_a, vecs[i].exp_peak);
         chk($sformatf("vec%0d_overflow", i), int'(ovf_a), 0);
      end

      // ---- timeout: ready stuck low after one issue (TIMEOUT=16)
      stuck_mode_a = 1'b1;
      ev_a = 1'b1;
      q_a.push_back(0);
      step();                       // first stall cycle (valid high)
      q_a.push_back(1);
      step();
      ev_a = 1'b0;
      repeat (13) step();           // 15th stall cycle
      chk("to_not_early", int'(to_a), 0);
      chk("to_busy_during_stall", int'(busy_a), 1);
      chk("to_pending_held", int'(pend_a), 1);
      clr_a = 1'b1;
      step();                       // 16th stall cycle
      chk("to_not_yet", int'(to_a), 0);
      step();
      clr_a = 1'b0;
      chk("to_set_wins_over_clr", int'(to_a), 1);
      chk("to_back_to_idle", int'(busy_a), 0);
      chk("to_pending_unchanged", int'(pend_a), 1);
      p0 = pulses_a;
      repeat (3) step();
      chk("to_no_retry_while_low", pulses_a - p0, 0);
      chk("to_sticky", int'(to_a), 1);
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      chk("to_cleared", int'(to_a), 0);
      stuck_mode_a = 1'b0;
      wait_quiet(1'b0, "to_release");
      chk("to_release_pulses", pulses_a - p0, 1);

      // ---- saturation on CNT_W=2 with ready held low
      force_low_b = 1'b1;
      repeat (2) step();
      p0 = pulses_b;
      for (int i = 0; i < 8; i++) begin
         ev_b = 1'b1;
         if (i < 3) q_b.push_back(i);
         step();
      end
      ev_b = 1'b0;
      step();
      chk("sat_pending", int'(pend_b), 3);
      chk("sat_overflow", int'(ovf_b), 1);
      chk("sat_no_issue_while_low", pulses_b - p0, 0);
      clr_b = 1'b1;
      step();
      clr_b = 1'b0;
      chk("sat_ovf_cleared", int'(ovf_b), 0);
      force_low_b = 1'b0;
      ev_b = 1'b1;                  // event at max on an issue edge
      q_b.push_back(3);
      step();
      ev_b = 1'b0;
      chk("sat_issue_edge_pending", int'(pend_b), 3);
      chk("sat_issue_edge_no_ovf", int'(ovf_b), 0);
      wait_quiet(1'b1, "sat");
      chk("sat_pulses", pulses_b - p0, 4);

      // ---- reset mid-handshake with pending=2
      for (int i = 0; i < 3; i++) begin
         ev_a = 1'b1;
         q_a.push_back(i);
         step();
      end
      ev_a = 1'b0;
      step();
      chk("rstmid_pending_before", int'(pend_a), 2);
      chk("rstmid_busy_before", int'(busy_a), 1);
      rstn_i = 1'b0;
      #1;
      chk("rstmid_valid", int'(valid_a), 0);
      chk("rstmid_pending", int'(pend_a), 0);
      chk("rstmid_busy", int'(busy_a), 0);
      chk("rstmid_flags", int'({ovf_a, to_a}), 0);
      q_a.delete();
      step();
      rstn_i = 1'b1;
      p0 = pulses_a;
      repeat (20) step();
      chk("rstmid_no_pulse_after", pulses_a - p0, 0);
      ev_a = 1'b1;
      q_a.push_back(0);
      step();
      ev_a = 1'b0;
      chk("rstmid_new_event_issues", int'(valid_a), 1);
      wait_quiet(1'b0, "rstmid");

`ifdef PULSE_EVT_TX_STATS_EN
      // ---- issued pulse counter
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      chk("stats_cleared", int'(issued_a), 0);
      drive_events_a(300, 9);
      wait_quiet(1'b0, "stats");
      chk("stats_300", int'(issued_a), 300);
      ev_a  = 1'b1;
      clr_a = 1'b1;
      q_a.push_back(0);
      step();
      ev_a  = 1'b0;
      clr_a = 1'b0;
      chk("stats_clr_with_issue", int'(issued_a), 1);
      wait_quiet(1'b0, "stats_end");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
`default_nettype wire
